// File: rtl/cond_pkg.sv
// Shared types and constants for the conditional-execution stage:
// condition encodings, NZCV bit positions and the flag write mask.
package cond_pkg;

  typedef enum logic [3:0] {
    EQ = 4'b0000,
    NE = 4'b0001,
    CS = 4'b0010,
    CC = 4'b0011,
    MI = 4'b0100,
    PL = 4'b0101,
    VS = 4'b0110,
    VC = 4'b0111,
    HI = 4'b1000,
    LS = 4'b1001,
    GE = 4'b1010,
    LT = 4'b1011,
    GT = 4'b1100,
    LE = 4'b1101,
    AL = 4'b1110,
    NV = 4'b1111
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // [1] enables the N,Z half, [0] enables the C,V half
  typedef logic [1:0] flagw_t;

endpackage

// File: rtl/cond_eval.sv
// Combinational condition evaluator: decides whether the instruction's
// condition field passes against the current NZCV flags.
module cond_eval
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    cond_ex = 1'b0;
    case (cond_e'(cond))
      EQ: cond_ex = z;
      NE: cond_ex = !z;
      CS: cond_ex = c;
      CC: cond_ex = !c;
      MI: cond_ex = n;
      PL: cond_ex = !n;
      VS: cond_ex = v;
      VC: cond_ex = !v;
      HI: cond_ex = c && !z;
      LS: cond_ex = !c || z;
      GE: cond_ex = (n == v);
      LT: cond_ex = (n != v);
      GT: cond_ex = !z && (n == v);
      LE: cond_ex = z || (n != v);
      AL: cond_ex = 1'b1;
      NV: cond_ex = 1'b0;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// NZCV flag register plus condition gating of PC/RF/DMEM requests.
// Optional saturating execute/squash counters when COND_STATS_EN is defined.
module cond_unit
  import cond_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  input  logic [3:0]       cond,
  input  logic [3:0]       alu_flags,
  input  flagw_t           flag_w,
  input  logic             no_write,
  input  logic             pc_src_in,
  input  logic             rf_en_in,
  input  logic             d_en_in,
  output logic             pc_src,
  output logic             rf_en,
  output logic             d_en,
  output logic             cond_ex,
  output logic [3:0]       flags
`ifdef COND_STATS_EN
  ,
  input  logic             stat_clr,
  output logic [CNT_W-1:0] exec_cnt,
  output logic [CNT_W-1:0] squash_cnt
`endif
);

  logic [3:0] flag_q;
  logic       flag_we;

  cond_eval u_eval (
    .cond    (cond),
    .flags   (flag_q),
    .cond_ex (cond_ex)
  );

  assign flags   = flag_q;
  assign flag_we = instr_valid && cond_ex;

  // Requests are held off for the whole reset window, not just at edges
  assign pc_src = rst_n && pc_src_in && cond_ex;
  assign rf_en  = rst_n && rf_en_in && cond_ex && !no_write;
  assign d_en   = rst_n && d_en_in && cond_ex;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_q <= 4'b0000;
    end else if (flag_we) begin
      if (flag_w[1]) begin
        flag_q[FLAG_N] <= alu_flags[FLAG_N];
        flag_q[FLAG_Z] <= alu_flags[FLAG_Z];
      end
      if (flag_w[0]) begin
        flag_q[FLAG_C] <= alu_flags[FLAG_C];
        flag_q[FLAG_V] <= alu_flags[FLAG_V];
      end
    end
  end

`ifdef COND_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exec_cnt   <= '0;
      squash_cnt <= '0;
    end else if (stat_clr) begin
      exec_cnt   <= '0;
      squash_cnt <= '0;
    end else if (instr_valid) begin
      if (cond_ex && (exec_cnt != {CNT_W{1'b1}}))
        exec_cnt <= exec_cnt + 1'b1;
      if (!cond_ex && (squash_cnt != {CNT_W{1'b1}}))
        squash_cnt <= squash_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cond_unit.sv
// Self-checking bench for cond_unit: directed table, corner sequences
// and randomized traffic against a flag-level reference model.
module tb_cond_unit;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          instr_valid;
  logic [3:0]    cond;
  logic [3:0]    alu_flags;
  logic [1:0]    flag_w;
  logic          no_write;
  logic          pc_src_in, rf_en_in, d_en_in;
  logic          pc_src, rf_en, d_en, cond_ex;
  logic [3:0]    flags;
  logic          sclr;
  logic [CW-1:0] exec_cnt, squash_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cond_unit #(.CNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .cond        (cond),
    .alu_flags   (alu_flags),
    .flag_w      (flag_w),
    .no_write    (no_write),
    .pc_src_in   (pc_src_in),
    .rf_en_in    (rf_en_in),
    .d_en_in     (d_en_in),
    .pc_src      (pc_src),
    .rf_en       (rf_en),
    .d_en        (d_en),
    .cond_ex     (cond_ex),
    .flags       (flags)
`ifdef COND_STATS_EN
    ,
    .stat_clr    (sclr),
    .exec_cnt    (exec_cnt),
    .squash_cnt  (squash_cnt)
`endif
  );

`ifndef COND_STATS_EN
  assign exec_cnt   = '0;
  assign squash_cnt = '0;
`endif

  // Reference: the low bit of the condition inverts a base predicate
  // selected by the upper three bits; AL/NV fall out as 1 and 0.
  function automatic logic ref_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c >> 1)
      0: base = z;
      1: base = cy;
      2: base = n;
      3: base = v;
      4: base = cy & ~z;
      5: base = (n == v);
      6: base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    return base ^ c[0];
  endfunction

  logic [3:0]    m_flags;
  int            m_exec, m_squash;
  logic          m_pass;
  logic [3:0]    m_mask;

  assign m_pass = ref_pass(cond, m_flags);
  assign m_mask = {flag_w[1], flag_w[1], flag_w[0], flag_w[0]};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_flags  <= 4'b0000;
      m_exec   <= 0;
      m_squash <= 0;
    end else begin
      if (instr_valid && m_pass)
        m_flags <= (m_flags & ~m_mask) | (alu_flags & m_mask);
      if (sclr) begin
        m_exec   <= 0;
        m_squash <= 0;
      end else if (instr_valid) begin
        if (m_pass) m_exec <= (m_exec >= 15) ? 15 : m_exec + 1;
        else        m_squash <= (m_squash >= 15) ? 15 : m_squash + 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic [3:0] c, input logic [3:0] af, input logic [1:0] fw,
                      input logic v, input logic nw, input logic pi, input logic ri,
                      input logic di);
    @(posedge clk);
    #1;
    cond = c; alu_flags = af; flag_w = fw; instr_valid = v;
    no_write = nw; pc_src_in = pi; rf_en_in = ri; d_en_in = di;
    #3;
  endtask

  typedef struct {
    logic [3:0] pre;
    logic [3:0] c;
    logic       nw;
    logic       ex;
    logic       pc;
    logic       rf;
    logic       de;
  } vec_t;

  vec_t tbl[16];

  initial begin
    tbl[0]  = '{4'b0100, 4'h0, 1'b0, 1, 1, 1, 1};
    tbl[1]  = '{4'b0100, 4'h1, 1'b0, 0, 0, 0, 0};
    tbl[2]  = '{4'b1000, 4'hA, 1'b0, 0, 0, 0, 0};
    tbl[3]  = '{4'b1000, 4'hB, 1'b0, 1, 1, 1, 1};
    tbl[4]  = '{4'b0010, 4'h8, 1'b0, 1, 1, 1, 1};
    tbl[5]  = '{4'b0010, 4'h9, 1'b0, 0, 0, 0, 0};
    tbl[6]  = '{4'b0110, 4'h8, 1'b0, 0, 0, 0, 0};
    tbl[7]  = '{4'b1001, 4'hC, 1'b0, 1, 1, 1, 1};
    tbl[8]  = '{4'b1001, 4'hD, 1'b0, 0, 0, 0, 0};
    tbl[9]  = '{4'b0000, 4'hF, 1'b0, 0, 0, 0, 0};
    tbl[10] = '{4'b0000, 4'hE, 1'b0, 1, 1, 1, 1};
    tbl[11] = '{4'b0001, 4'h6, 1'b0, 1, 1, 1, 1};
    tbl[12] = '{4'b1000, 4'h4, 1'b0, 1, 1, 1, 1};
    tbl[13] = '{4'b1000, 4'h5, 1'b0, 0, 0, 0, 0};
    tbl[14] = '{4'b0100, 4'hD, 1'b1, 1, 1, 0, 1};
    tbl[15] = '{4'b1101, 4'hC, 1'b0, 0, 0, 0, 0};

    rst_n = 1'b0; sclr = 1'b0;
    cond = 4'hE; alu_flags = 4'h0; flag_w = 2'b00; instr_valid = 1'b0;
    no_write = 1'b0; pc_src_in = 1'b0; rf_en_in = 1'b1; d_en_in = 1'b0;
    #2;
    check("reset_rf_en", rf_en, 1'b0);
    check("reset_flags", flags, 4'b0000);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #3;
    check("post_reset_rf_en", rf_en, 1'b1);
    check("post_reset_flags", flags, 4'b0000);

    // Test plan: load Z, then EQ/NE see it one cycle later
    step(4'hE, 4'b0100, 2'b11, 1, 0, 0, 0, 0);
    check("no_self_forward", flags, 4'b0000);
    step(4'h0, 4'b0000, 2'b00, 1, 0, 1, 0, 0);
    check("eq_flags", flags, 4'b0100);
    check("eq_cond_ex", cond_ex, 1'b1);
    check("eq_pc_src", pc_src, 1'b1);
    step(4'h1, 4'b0000, 2'b00, 1, 0, 1, 0, 0);
    check("ne_pc_src", pc_src, 1'b0);

    // Independent halves of the flag write mask
    step(4'hE, 4'b1000, 2'b11, 1, 0, 0, 0, 0);
    step(4'hE, 4'b0111, 2'b01, 1, 0, 0, 0, 0);
    check("half_pre", flags, 4'b1000);
    step(4'hE, 4'b0000, 2'b10, 1, 0, 0, 0, 0);
    check("half_cv", flags, 4'b1011);
    step(4'hE, 4'b0000, 2'b00, 1, 0, 0, 0, 0);
    check("half_nz", flags, 4'b0011);

    // Failing condition blocks all flag writes
    step(4'hE, 4'b0100, 2'b11, 1, 0, 0, 0, 0);
    step(4'h1, 4'b1111, 2'b11, 1, 0, 0, 0, 1);
    check("fail_d_en", d_en, 1'b0);
    step(4'hE, 4'b0000, 2'b00, 1, 0, 0, 0, 0);
    check("fail_hold", flags, 4'b0100);

    // Compare-class: no register write, flags still update
    step(4'hE, 4'b0110, 2'b11, 1, 1, 0, 1, 0);
    check("cmp_rf_en", rf_en, 1'b0);
    step(4'hE, 4'b0000, 2'b00, 0, 0, 0, 1, 0);
    check("cmp_flags", flags, 4'b0110);

    // instr_valid=0 blocks flag write but not gated outputs
    step(4'hE, 4'b1001, 2'b11, 0, 0, 1, 1, 1);
    check("invalid_rf_en", rf_en, 1'b1);
    step(4'hE, 4'b0000, 2'b00, 0, 0, 0, 0, 0);
    check("invalid_hold", flags, 4'b0110);

    // Directed condition table
    for (int i = 0; i < 16; i++) begin
      step(4'hE, tbl[i].pre, 2'b11, 1, 0, 0, 0, 0);
      step(tbl[i].c, 4'b0000, 2'b00, 1, tbl[i].nw, 1, 1, 1);
      check($sformatf("tbl%0d_flags", i), flags, tbl[i].pre);
      check($sformatf("tbl%0d_cond_ex", i), cond_ex, tbl[i].ex);
      check($sformatf("tbl%0d_pc_src", i), pc_src, tbl[i].pc);
      check($sformatf("tbl%0d_rf_en", i), rf_en, tbl[i].rf);
      check($sformatf("tbl%0d_d_en", i), d_en, tbl[i].de);
    end

    // Reset asserted mid-cycle with a write pending
    step(4'hE, 4'b1111, 2'b11, 1, 0, 0, 1, 0);
    step(4'hE, 4'b0101, 2'b11, 1, 0, 0, 1, 0);
    check("pre_async_flags", flags, 4'b1111);
    rst_n = 1'b0;
    #1;
    check("async_flags", flags, 4'b0000);
    check("async_rf_en", rf_en, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #3;
    check("async_lost_write", flags, 4'b0000);

`ifdef COND_STATS_EN
    check("stats_reset_exec", exec_cnt, 4'd0);
    check("stats_reset_squash", squash_cnt, 4'd0);
    for (int i = 0; i < 20; i++) step(4'hE, 4'b0000, 2'b00, 1, 0, 0, 0, 0);
    step(4'hE, 4'b0000, 2'b00, 0, 0, 0, 0, 0);
    check("stats_exec_sat", exec_cnt, 4'd15);
    sclr = 1'b1;
    step(4'hF, 4'b0000, 2'b00, 1, 0, 0, 0, 0);
    step(4'hF, 4'b0000, 2'b00, 1, 0, 0, 0, 0);
    sclr = 1'b0;
    check("stats_clr_exec", exec_cnt, 4'd0);
    check("stats_clr_squash", squash_cnt, 4'd0);
    step(4'hE, 4'b0000, 2'b00, 0, 0, 0, 0, 0);
    check("stats_squash_one", squash_cnt, 4'd1);
`endif

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      sclr = ($urandom_range(0, 31) == 0);
      step(4'($urandom), 4'($urandom), 2'($urandom), 1'($urandom_range(0, 3) != 0),
           1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      check("rnd_flags", flags, m_flags);
      check("rnd_cond_ex", cond_ex, m_pass);
      check("rnd_pc_src", pc_src, pc_src_in & m_pass);
      check("rnd_rf_en", rf_en, rf_en_in & m_pass & ~no_write);
      check("rnd_d_en", d_en, d_en_in & m_pass);
`ifdef COND_STATS_EN
      check("rnd_exec", exec_cnt, m_exec);
      check("rnd_squash", squash_cnt, m_squash);
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
